// File: rtl/bus_wait_ctrl_if.sv
// Bus-side signal bundle between the CPU/mapper side and the wait-state
// controller: registered mapper address and cycle qualifiers in, ready,
// chip selects and error reporting out.
interface bus_wait_ctrl_if;
   logic [19:0] address;
   logic        map;
   logic        rw;
   logic        io_en;
   logic        fast;
   logic        ext_ack;
   logic        ready;
   logic        ram_cs;
   logic        rom_cs;
   logic        io_cs;
   logic        ext_cs;
   logic        bus_error;
   logic        bus_error_rw;

   // CPU/mapper side: drives the cycle, observes ready and selects
   modport master (
      output address, map, rw, io_en, fast, ext_ack,
      input  ready, ram_cs, rom_cs, io_cs, ext_cs, bus_error, bus_error_rw
   );

   // Controller side
   modport slave (
      input  address, map, rw, io_en, fast, ext_ack,
      output ready, ram_cs, rom_cs, io_cs, ext_cs, bus_error, bus_error_rw
   );
endinterface

// File: rtl/bus_wait_ctrl.sv
// Bus wait-state controller sitting behind the 4510 mapper.
// Decodes the registered physical address into RAM/ROM/IO/external
// regions, drives one chip select, and stretches each bus cycle with
// a per-region wait count or an external acknowledge with timeout.
// ready is derived only from registered state and the mapper's
// registered address so no loop forms through the mapper's next-address mux.
module bus_wait_ctrl #(
   parameter int unsigned RAM_WAIT    = 0,
   parameter int unsigned ROM_WAIT    = 2,
   parameter int unsigned IO_WAIT     = 1,
   parameter int unsigned EXT_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 8
) (
   input  logic           clk,
   input  logic           reset,
   bus_wait_ctrl_if.slave bus
);

   localparam logic [1:0] S_IDLE = 2'b00;
   localparam logic [1:0] S_WAIT = 2'b01;
   localparam logic [1:0] S_EXT  = 2'b10;

   localparam logic [CNT_W-1:0] C_ZERO      = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] C_RAM_WAIT  = CNT_W'(RAM_WAIT);
   localparam logic [CNT_W-1:0] C_ROM_WAIT  = CNT_W'(ROM_WAIT);
   localparam logic [CNT_W-1:0] C_IO_WAIT   = CNT_W'(IO_WAIT);
   localparam logic [CNT_W-1:0] C_EXT_START = CNT_W'(EXT_TIMEOUT - 1);

   logic [1:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_bus_error;
   logic             r_bus_error_rw;

   logic             w_ram_sel;
   logic             w_rom_sel;
   logic             w_io_sel;
   logic             w_ext_sel;
   logic [CNT_W-1:0] w_wait;
   logic             w_ack;
   logic             w_ready;
   logic             w_timeout;
   logic [1:0]       w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;

   // Region decode; I/O window has priority and is hidden by a mapper hit
   always_comb begin
      w_ram_sel = 1'b0;
      w_rom_sel = 1'b0;
      w_io_sel  = 1'b0;
      w_ext_sel = 1'b0;
      if (bus.io_en && !bus.map && (bus.address[19:12] == 8'h0D)) begin
         w_io_sel = 1'b1;
      end else if (bus.address[19:17] == 3'b001) begin
         w_rom_sel = 1'b1;
      end else if (bus.address[19:17] == 3'b000) begin
         w_ram_sel = 1'b1;
      end else begin
         w_ext_sel = 1'b1;
      end
   end

   // Wait count for the decoded region; fast collapses RAM/ROM waits
   always_comb begin
      w_wait = C_ZERO;
      if (w_io_sel) begin
         w_wait = C_IO_WAIT;
      end else if (w_rom_sel) begin
         w_wait = bus.fast ? C_ZERO : C_ROM_WAIT;
      end else if (w_ram_sel) begin
         w_wait = bus.fast ? C_ZERO : C_RAM_WAIT;
      end else begin
         w_wait = C_ZERO;
      end
   end

   // External acknowledge only counts while the external bus is selected
   assign w_ack = bus.ext_ack & w_ext_sel;

   // Cycle sequencer: ready, next state, counter and timeout detection
   always_comb begin
      w_ready     = 1'b0;
      w_timeout   = 1'b0;
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         S_IDLE: begin
            if (w_ext_sel) begin
               if (w_ack) begin
                  w_ready = 1'b1;
               end else begin
                  w_cnt_nxt   = C_EXT_START;
                  w_state_nxt = S_EXT;
               end
            end else if (w_wait == C_ZERO) begin
               w_ready = 1'b1;
            end else begin
               w_cnt_nxt   = w_wait - C_ONE;
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (r_cnt == C_ZERO) begin
               w_ready     = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - C_ONE;
            end
         end
         S_EXT: begin
            // ack wins over a simultaneous expiry, so no error in that case
            if (w_ack) begin
               w_ready     = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (r_cnt == C_ZERO) begin
               w_ready     = 1'b1;
               w_timeout   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_cnt_nxt = r_cnt - C_ONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = C_ZERO;
         end
      endcase
   end

   // State, counter and error pulse registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_cnt          <= C_ZERO;
         r_bus_error    <= 1'b0;
         r_bus_error_rw <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_bus_error <= w_timeout;
         if (w_timeout) begin
            r_bus_error_rw <= bus.rw;
         end else begin
            r_bus_error_rw <= r_bus_error_rw;
         end
      end
   end

   // ready is held low while reset is applied
   assign bus.ready        = w_ready & ~reset;
   assign bus.ram_cs       = w_ram_sel;
   assign bus.rom_cs       = w_rom_sel;
   assign bus.io_cs        = w_io_sel;
   assign bus.ext_cs       = w_ext_sel;
   assign bus.bus_error    = r_bus_error;
   assign bus.bus_error_rw = r_bus_error_rw;

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// Directed bench for bus_wait_ctrl. Instance u_a uses default parameters,
// u_b uses ROM_WAIT=5 and EXT_TIMEOUT=4; both see the same inputs.
// Inputs change 1 time unit after posedge, outputs are checked at negedge.
module tb_bus_wait_ctrl;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   bus_wait_ctrl_if ba ();
   bus_wait_ctrl_if bb ();

   always #5 clk = ~clk;

   assign bb.address = ba.address;
   assign bb.map     = ba.map;
   assign bb.rw      = ba.rw;
   assign bb.io_en   = ba.io_en;
   assign bb.fast    = ba.fast;
   assign bb.ext_ack = ba.ext_ack;

   bus_wait_ctrl u_a (
      .clk   (clk),
      .reset (reset),
      .bus   (ba)
   );

   bus_wait_ctrl #(
      .ROM_WAIT    (5),
      .EXT_TIMEOUT (4)
   ) u_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bb)
   );

   task automatic chk(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset      = 1'b1;
      ba.address = 20'h01234;
      ba.map     = 1'b0;
      ba.rw      = 1'b1;
      ba.io_en   = 1'b0;
      ba.fast    = 1'b0;
      ba.ext_ack = 1'b0;

      // reset state: ready forced low even though RAM decodes zero-wait
      @(negedge clk);
      chk("rst_ready_a", ba.ready, 1'b0);
      chk("rst_ready_b", bb.ready, 1'b0);
      chk("rst_ram_cs", ba.ram_cs, 1'b1);
      chk("rst_bus_error", ba.bus_error, 1'b0);
      chk("rst_bus_error_rw", ba.bus_error_rw, 1'b0);
      step();
      reset = 1'b0;

      // RAM, zero wait: ready every clock
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ram_ready", ba.ready, 1'b1);
         chk("ram_cs", ba.ram_cs, 1'b1);
         chk("ram_ext_cs", ba.ext_cs, 1'b0);
         step();
      end

      // ROM, two stalls: ready 0,0,1
      ba.address = 20'h2A000;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rom_ready", ba.ready, (i == 2) ? 1'b1 : 1'b0);
         chk("rom_cs", ba.rom_cs, 1'b1);
         step();
      end

      // ROM with fast: immediate ready
      ba.fast = 1'b1;
      @(negedge clk);
      chk("rom_fast_ready", ba.ready, 1'b1);
      chk("rom_fast_cs", ba.rom_cs, 1'b1);
      step();
      ba.fast = 1'b0;

      // I/O window: one stall
      ba.io_en   = 1'b1;
      ba.address = 20'h0D020;
      @(negedge clk);
      chk("io_cs_0", ba.io_cs, 1'b1);
      chk("io_ram_cs_0", ba.ram_cs, 1'b0);
      chk("io_ready_0", ba.ready, 1'b0);
      step();
      @(negedge clk);
      chk("io_cs_1", ba.io_cs, 1'b1);
      chk("io_ready_1", ba.ready, 1'b1);
      step();

      // same address with mapper hit falls through to RAM
      ba.map = 1'b1;
      @(negedge clk);
      chk("io_map_ram_cs", ba.ram_cs, 1'b1);
      chk("io_map_io_cs", ba.io_cs, 1'b0);
      chk("io_map_ready", ba.ready, 1'b1);
      step();
      ba.map   = 1'b0;
      ba.io_en = 1'b0;

      // external with ack already present: completes in first clock
      ba.address = 20'h80000;
      ba.ext_ack = 1'b1;
      @(negedge clk);
      chk("ext_cs_quick", ba.ext_cs, 1'b1);
      chk("ext_ready_quick", ba.ready, 1'b1);
      step();
      ba.ext_ack = 1'b0;

      // external, ack raised on the 4th stall clock
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("ext_stall_ready", ba.ready, 1'b0);
         chk("ext_stall_cs", ba.ext_cs, 1'b1);
         step();
      end
      ba.ext_ack = 1'b1;
      @(negedge clk);
      chk("ext_ack_ready", ba.ready, 1'b1);
      step();
      ba.ext_ack = 1'b0;
      ba.address = 20'h00100;
      @(negedge clk);
      chk("ext_ack_no_error", ba.bus_error, 1'b0);
      chk("ext_after_ram_ready", ba.ready, 1'b1);
      step();

      // reset both instances before the short-timeout tests
      reset = 1'b1;
      @(negedge clk);
      chk("rst2_ready_a", ba.ready, 1'b0);
      step();
      reset = 1'b0;

      // timeout (EXT_TIMEOUT=4), rw=0
      ba.rw      = 1'b0;
      ba.address = 20'h80000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("to0_stall_ready", bb.ready, 1'b0);
         chk("to0_stall_err", bb.bus_error, 1'b0);
         step();
      end
      @(negedge clk);
      chk("to0_done_ready", bb.ready, 1'b1);
      chk("to0_done_err", bb.bus_error, 1'b0);
      step();
      ba.address = 20'h00100;
      @(negedge clk);
      chk("to0_pulse", bb.bus_error, 1'b1);
      chk("to0_pulse_rw", bb.bus_error_rw, 1'b0);
      chk("to0_next_ready", bb.ready, 1'b1);
      step();
      @(negedge clk);
      chk("to0_pulse_end", bb.bus_error, 1'b0);
      step();

      // timeout again with rw=1: separate pulse, rw latched
      ba.rw      = 1'b1;
      ba.address = 20'h80000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("to1_stall_ready", bb.ready, 1'b0);
         step();
      end
      @(negedge clk);
      chk("to1_done_ready", bb.ready, 1'b1);
      step();
      ba.address = 20'h00100;
      @(negedge clk);
      chk("to1_pulse", bb.bus_error, 1'b1);
      chk("to1_pulse_rw", bb.bus_error_rw, 1'b1);
      step();
      @(negedge clk);
      chk("to1_pulse_end", bb.bus_error, 1'b0);
      step();

      // ack coincident with counter expiry: ack wins, no error
      ba.rw      = 1'b0;
      ba.address = 20'h80000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("co_stall_ready", bb.ready, 1'b0);
         step();
      end
      ba.ext_ack = 1'b1;
      @(negedge clk);
      chk("co_ready", bb.ready, 1'b1);
      step();
      ba.ext_ack = 1'b0;
      ba.address = 20'h00100;
      @(negedge clk);
      chk("co_no_error", bb.bus_error, 1'b0);
      chk("co_rw_held", bb.bus_error_rw, 1'b1);
      step();

      // reset mid-WAIT on ROM (ROM_WAIT=5), two cycles in
      ba.address = 20'h2A000;
      @(negedge clk);
      chk("rw_idle_ready", bb.ready, 1'b0);
      step();
      @(negedge clk);
      chk("rw_wait_ready", bb.ready, 1'b0);
      step();
      reset = 1'b1;
      #1;
      chk("rw_rst_ready", bb.ready, 1'b0);
      chk("rw_rst_err", bb.bus_error, 1'b0);
      chk("rw_rst_err_rw", bb.bus_error_rw, 1'b0);
      ba.address = 20'h00100;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("rw_post_ready_0", bb.ready, 1'b1);
      chk("rw_post_ram_cs", bb.ram_cs, 1'b1);
      step();
      @(negedge clk);
      chk("rw_post_ready_1", bb.ready, 1'b1);
      step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
